// File: rtl/rob_commit_unit_if.sv
// rtl/rob_commit_unit_if.sv - dispatch, CDB, query and retire bundle between the core and the reorder buffer
interface rob_commit_unit_if #(parameter int ROB_SZ_LOG = 3);
    localparam int TW = ROB_SZ_LOG + 1;

    logic          rdy;
    logic          alloc_valid;
    logic [4:0]    alloc_rd;
    logic          alloc_br;
    logic [TW-1:0] alloc_tag;
    logic          full;
    logic          wb_valid;
    logic [TW-1:0] wb_tag;
    logic [31:0]   wb_data;
    logic          wb_mispred;
    logic [31:0]   wb_target;
    logic [TW-1:0] qry_tag;
    logic          qry_ready;
    logic [31:0]   qry_data;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_res;
    logic [TW-1:0] commit_tag;
    logic          flush;
    logic [31:0]   flush_pc;

    modport master (
        output rdy, alloc_valid, alloc_rd, alloc_br, wb_valid, wb_tag, wb_data,
               wb_mispred, wb_target, qry_tag,
        input  alloc_tag, full, qry_ready, qry_data, commit_valid, commit_rd,
               commit_res, commit_tag, flush, flush_pc
    );

    modport slave (
        input  rdy, alloc_valid, alloc_rd, alloc_br, wb_valid, wb_tag, wb_data,
               wb_mispred, wb_target, qry_tag,
        output alloc_tag, full, qry_ready, qry_data, commit_valid, commit_rd,
               commit_res, commit_tag, flush, flush_pc
    );
endinterface

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - in-order retire reorder buffer; ROB_WB_BYPASS_EN forwards the same-cycle CDB to queries
module rob_commit_unit #(
    parameter int ROB_SZ_LOG = 3
) (
    input logic               clk,
    input logic               rst,
    rob_commit_unit_if.slave  bus
);
    localparam int ROB_SZ = 1 << ROB_SZ_LOG;
    localparam int TW     = ROB_SZ_LOG + 1;
    localparam logic [TW-1:0] TAG_ONE = TW'(1);
    localparam logic [TW-1:0] TAG_MAX = TW'(ROB_SZ);

    logic [ROB_SZ-1:0] busy, ready, br, mispred;
    logic [4:0]        rd     [ROB_SZ];
    logic [31:0]       data   [ROB_SZ];
    logic [31:0]       target [ROB_SZ];

    logic [TW-1:0] head, tail, count;
    logic          flush_pend, flush_q;
    logic [31:0]   pend_pc, flush_pc_q;
    logic          commit_valid_q;
    logic [4:0]    commit_rd_q;
    logic [31:0]   commit_res_q;
    logic [TW-1:0] commit_tag_q;

    logic [ROB_SZ_LOG-1:0] head_idx, tail_idx, wb_idx, qry_idx;
    logic full_i, alloc_ok, wb_hit, retire;
    logic qry_ready_i;
    logic [31:0] qry_data_i;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] t);
        return (t == TAG_MAX) ? TAG_ONE : t + TAG_ONE;
    endfunction

    function automatic logic tag_live(input logic [TW-1:0] t);
        return (t != '0) && (t <= TAG_MAX);
    endfunction

    // Tags run 1..ROB_SZ, so the low bits give a unique slot (ROB_SZ lands on slot 0).
    assign head_idx = head[ROB_SZ_LOG-1:0];
    assign tail_idx = tail[ROB_SZ_LOG-1:0];
    assign wb_idx   = bus.wb_tag[ROB_SZ_LOG-1:0];
    assign qry_idx  = bus.qry_tag[ROB_SZ_LOG-1:0];

    assign full_i   = (count == TAG_MAX) | flush_pend | flush_q;
    assign alloc_ok = bus.alloc_valid & ~full_i;
    assign wb_hit   = bus.wb_valid & tag_live(bus.wb_tag) & busy[wb_idx] & ~flush_pend & ~flush_q;
    assign retire   = busy[head_idx] & ready[head_idx];

    always_comb begin
        qry_ready_i = tag_live(bus.qry_tag) & busy[qry_idx] & ready[qry_idx];
        qry_data_i  = qry_ready_i ? data[qry_idx] : '0;
`ifdef ROB_WB_BYPASS_EN
        if (bus.wb_valid && (bus.qry_tag != '0) && (bus.wb_tag == bus.qry_tag)) begin
            qry_ready_i = 1'b1;
            qry_data_i  = bus.wb_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= '0;
            ready          <= '0;
            head           <= TAG_ONE;
            tail           <= TAG_ONE;
            count          <= '0;
            flush_pend     <= 1'b0;
            flush_q        <= 1'b0;
            pend_pc        <= '0;
            flush_pc_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_res_q   <= '0;
            commit_tag_q   <= '0;
        end else if (bus.rdy) begin
            commit_valid_q <= 1'b0;
            flush_q        <= flush_pend;
            flush_pend     <= 1'b0;
            if (flush_pend)
                flush_pc_q <= pend_pc;

            if (wb_hit) begin
                ready[wb_idx]   <= 1'b1;
                data[wb_idx]    <= bus.wb_data;
                // A mispredict flag only means something on a branch entry.
                mispred[wb_idx] <= bus.wb_mispred & br[wb_idx];
                target[wb_idx]  <= bus.wb_target;
            end

            if (alloc_ok) begin
                busy[tail_idx]  <= 1'b1;
                ready[tail_idx] <= 1'b0;
                rd[tail_idx]    <= bus.alloc_rd;
                br[tail_idx]    <= bus.alloc_br;
                tail            <= tag_next(tail);
            end

            if (retire) begin
                commit_valid_q  <= (rd[head_idx] != 5'd0);
                commit_rd_q     <= rd[head_idx];
                commit_res_q    <= data[head_idx];
                commit_tag_q    <= head;
                busy[head_idx]  <= 1'b0;
                ready[head_idx] <= 1'b0;
                head            <= tag_next(head);
            end

            count <= count + {{(TW-1){1'b0}}, alloc_ok} - {{(TW-1){1'b0}}, retire};

            // Mispredicted retire drops everything younger, overriding this cycle's alloc/wb.
            if (retire && mispred[head_idx]) begin
                busy       <= '0;
                ready      <= '0;
                head       <= TAG_ONE;
                tail       <= TAG_ONE;
                count      <= '0;
                flush_pend <= 1'b1;
                pend_pc    <= target[head_idx];
            end
        end
    end

    assign bus.alloc_tag    = tail;
    assign bus.full         = full_i;
    assign bus.qry_ready    = qry_ready_i;
    assign bus.qry_data     = qry_data_i;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_res   = commit_res_q;
    assign bus.commit_tag   = commit_tag_q;
    assign bus.flush        = flush_q;
    assign bus.flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - directed bench for rob_commit_unit with an in-order queue model
module tb_rob_commit_unit;
    localparam int SZ = 8;
`ifdef ROB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk, rst;
    int   checks = 0;
    int   failures = 0;

    rob_commit_unit_if #(.ROB_SZ_LOG(3)) bus ();
    rob_commit_unit #(.ROB_SZ_LOG(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic        br;
        logic        done;
        logic [31:0] data;
        logic        mis;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          m_next_tag = 1;
    logic        m_pend = 0, m_fl = 0, m_cv = 0;
    logic [31:0] m_pend_pc = 0, m_fpc = 0, m_cres = 0;
    logic [4:0]  m_crd = 0;
    int          m_ctag = 0;
    logic        started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic was_pend, was_fl, full_now, ret;
        ent_t h, e;
        if (rst) begin
            q.delete();
            m_next_tag = 1; m_pend = 0; m_fl = 0; m_pend_pc = 0; m_fpc = 0;
            m_cv = 0; m_crd = 0; m_cres = 0; m_ctag = 0;
            started = 1;
        end else if (bus.rdy) begin
            was_pend = m_pend;
            was_fl   = m_fl;
            full_now = (q.size() == SZ) || was_pend || was_fl;
            ret      = (q.size() > 0) && q[0].done;
            if (ret) h = q[0];
            m_cv   = 0;
            m_fl   = was_pend;
            if (was_pend) m_fpc = m_pend_pc;
            m_pend = 0;
            if (bus.wb_valid && !was_pend && !was_fl)
                for (int i = 0; i < q.size(); i++)
                    if (q[i].tag == int'(bus.wb_tag)) begin
                        e = q[i];
                        e.done = 1; e.data = bus.wb_data;
                        e.mis = bus.wb_mispred & e.br; e.tgt = bus.wb_target;
                        q[i] = e;
                    end
            if (bus.alloc_valid && !full_now) begin
                e = '{tag: m_next_tag, rd: bus.alloc_rd, br: bus.alloc_br, done: 0,
                      data: 0, mis: 0, tgt: 0};
                q.push_back(e);
                m_next_tag = (m_next_tag % SZ) + 1;
            end
            if (ret) begin
                void'(q.pop_front());
                m_cv = (h.rd != 0); m_crd = h.rd; m_cres = h.data; m_ctag = h.tag;
                if (h.mis) begin
                    q.delete();
                    m_next_tag = 1; m_pend = 1; m_pend_pc = h.tgt;
                end
            end
        end
    endtask

    task automatic model_qry(output logic r, output logic [31:0] d);
        r = 0; d = 0;
        foreach (q[i])
            if (q[i].tag == int'(bus.qry_tag) && q[i].done) begin r = 1; d = q[i].data; end
        if (BYP && bus.wb_valid && bus.qry_tag != 0 && bus.wb_tag == bus.qry_tag) begin
            r = 1; d = bus.wb_data;
        end
    endtask

    initial begin
        logic        er;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("alloc_tag", 32'(bus.alloc_tag), 32'(m_next_tag));
                chk("full", 32'(bus.full), 32'((q.size() == SZ) || m_pend || m_fl));
                chk("commit_valid", 32'(bus.commit_valid), 32'(m_cv));
                if (m_cv) begin
                    chk("commit_rd", 32'(bus.commit_rd), 32'(m_crd));
                    chk("commit_res", bus.commit_res, m_cres);
                    chk("commit_tag", 32'(bus.commit_tag), 32'(m_ctag));
                end
                chk("flush", 32'(bus.flush), 32'(m_fl));
                chk("flush_pc", bus.flush_pc, m_fpc);
                model_qry(er, ed);
                chk("qry_ready", 32'(bus.qry_ready), 32'(er));
                if (er) chk("qry_data", bus.qry_data, ed);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle();
        bus.rdy = 1; bus.alloc_valid = 0; bus.alloc_rd = 0; bus.alloc_br = 0;
        bus.wb_valid = 0; bus.wb_tag = 0; bus.wb_data = 0; bus.wb_mispred = 0;
        bus.wb_target = 0; bus.qry_tag = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic b);
        bus.alloc_valid = 1; bus.alloc_rd = rd; bus.alloc_br = b;
        tick();
        bus.alloc_valid = 0; bus.alloc_br = 0;
    endtask

    task automatic wb(input int tag, input logic [31:0] d, input logic mis, input logic [31:0] tg);
        bus.wb_valid = 1; bus.wb_tag = 4'(tag); bus.wb_data = d;
        bus.wb_mispred = mis; bus.wb_target = tg;
        tick();
        bus.wb_valid = 0; bus.wb_mispred = 0;
    endtask

    initial begin
        rst = 1;
        idle();

        // fill to 8, then a refused 9th alloc
        do_reset();
        chk("rst_alloc_tag", 32'(bus.alloc_tag), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
        chk("rst_flush_pc", bus.flush_pc, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            chk("alloc_tag_seq", 32'(bus.alloc_tag), 32'(i));
            alloc(5'(i), 0);
        end
        chk("full_after_8", 32'(bus.full), 32'd1);
        chk("tag_wrapped", 32'(bus.alloc_tag), 32'd1);
        alloc(5'd9, 0);
        chk("ninth_ignored", 32'(bus.full), 32'd1);

        // out-of-order writeback, in-order retire
        do_reset();
        alloc(5'd3, 0);
        alloc(5'd4, 0);
        wb(0, 32'hff, 0, 0);
        wb(6, 32'hee, 0, 0);
        wb(2, 32'h22, 0, 0);
        chk("no_ooo_retire", 32'(bus.commit_valid), 32'd0);
        wb(1, 32'h11, 0, 0);
        tick();
        chk("c1_tag", 32'(bus.commit_tag), 32'd1);
        chk("c1_rd", 32'(bus.commit_rd), 32'd3);
        chk("c1_res", bus.commit_res, 32'h11);
        tick();
        chk("c2_tag", 32'(bus.commit_tag), 32'd2);
        chk("c2_res", bus.commit_res, 32'h22);
        tick();
        chk("c_pulse_end", 32'(bus.commit_valid), 32'd0);

        // mispredicted branch at head
        do_reset();
        alloc(5'd5, 1);
        alloc(5'd6, 0);
        alloc(5'd7, 0);
        wb(2, 32'h2, 0, 0);
        wb(3, 32'h3, 0, 0);
        wb(1, 32'h44, 1, 32'h100);
        tick();
        chk("br_commit_valid", 32'(bus.commit_valid), 32'd1);
        chk("br_commit_rd", 32'(bus.commit_rd), 32'd5);
        chk("br_flush_early", 32'(bus.flush), 32'd0);
        chk("br_full_pend", 32'(bus.full), 32'd1);
        bus.alloc_valid = 1; bus.alloc_rd = 5'd9;
        tick();
        chk("flush_pulse", 32'(bus.flush), 32'd1);
        chk("flush_pc_val", bus.flush_pc, 32'h100);
        tick();
        bus.alloc_valid = 0;
        chk("flush_done", 32'(bus.flush), 32'd0);
        chk("post_flush_tag", 32'(bus.alloc_tag), 32'd1);
        chk("post_flush_full", 32'(bus.full), 32'd0);
        chk("flush_pc_hold", bus.flush_pc, 32'h100);

        // full with ready head: retire happens, alloc refused, then accepted at wrapped tail
        do_reset();
        for (int i = 1; i <= 8; i++) alloc(5'(i), 0);
        wb(1, 32'ha1, 0, 0);
        bus.alloc_valid = 1; bus.alloc_rd = 5'd9;
        #1 chk("full_before_retire", 32'(bus.full), 32'd1);
        tick();
        chk("full_retire_tag", 32'(bus.commit_tag), 32'd1);
        chk("full_refused_tag", 32'(bus.alloc_tag), 32'd1);
        tick();
        bus.alloc_valid = 0;
        chk("wrap_alloc_tag", 32'(bus.alloc_tag), 32'd2);
        chk("wrap_full", 32'(bus.full), 32'd1);

        // query vs same-cycle CDB, then rdy freeze
        do_reset();
        alloc(5'd1, 0);
        alloc(5'd2, 0);
        alloc(5'd3, 0);
        bus.wb_valid = 1; bus.wb_tag = 4'd3; bus.wb_data = 32'h33; bus.qry_tag = 4'd3;
        #1 chk("qry_same_cycle", 32'(bus.qry_ready), 32'(BYP));
        tick();
        bus.wb_valid = 0;
        #1 chk("qry_next_cycle", 32'(bus.qry_ready), 32'd1);
        chk("qry_data_val", bus.qry_data, 32'h33);
        wb(1, 32'h55, 0, 0);
        bus.rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frozen_commit", 32'(bus.commit_valid), 32'd0);
            chk("frozen_tag", 32'(bus.alloc_tag), 32'd4);
        end
        bus.rdy = 1;
        tick();
        chk("unfrozen_commit", 32'(bus.commit_valid), 32'd1);
        chk("unfrozen_res", bus.commit_res, 32'h55);

        // reset while a flush is pending
        do_reset();
        alloc(5'd0, 1);
        wb(1, 32'h0, 1, 32'h200);
        tick();
        chk("br_rd0_no_valid", 32'(bus.commit_valid), 32'd0);
        chk("pend_full", 32'(bus.full), 32'd1);
        rst = 1;
        tick();
        chk("rst_kills_flush", 32'(bus.flush), 32'd0);
        chk("rst_pend_tag", 32'(bus.alloc_tag), 32'd1);
        rst = 0;
        tick();
        chk("no_late_flush", 32'(bus.flush), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
